// File: rtl/sample_scheduler.sv
// Head-of-pipeline sequencer: accepts a sample stream, walks it through the image
// in BIP order (z, then x, then y) and issues it with coordinates, flags and an idle gap.
module sample_scheduler #(
  parameter int DATA_WIDH = 20,
  parameter int XW        = 8,
  parameter int YW        = 8,
  parameter int ZW        = 8,
  parameter int GW        = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [XW-1:0]        nx_i,
  input  logic [YW-1:0]        ny_i,
  input  logic [ZW-1:0]        nz_i,
  input  logic [GW-1:0]        gap_i,
  input  logic                 s_valid_i,
  input  logic [DATA_WIDH-1:0] s_data_i,
  output logic                 s_ready_o,
  output logic                 en_o,
  output logic [DATA_WIDH-1:0] data_o,
  output logic [XW-1:0]        x_o,
  output logic [YW-1:0]        y_o,
  output logic [ZW-1:0]        z_o,
  output logic                 first_x_o,
  output logic                 first_y_o,
  output logic                 first_z_o,
  output logic                 last_o,
  output logic                 busy_o,
  output logic                 done_o
);

  typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

  typedef struct packed {
    logic [XW-1:0] nx;
    logic [YW-1:0] ny;
    logic [ZW-1:0] nz;
    logic [GW-1:0] gap;
  } cfg_t;

  state_t        state, state_nx;
  cfg_t          cfg;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [ZW-1:0] z;
  logic [GW-1:0] gcnt;
  logic          accept;
  logic          last_smp;

  // Ready decodes registered state only; abort drops any sample offered that cycle.
  assign s_ready_o = (state == RUN);
  assign busy_o    = (state != IDLE);
  assign accept    = s_valid_i & s_ready_o & ~abort_i;
  assign last_smp  = (x == cfg.nx) && (y == cfg.ny) && (z == cfg.nz);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start_i) state_nx = RUN;
      RUN: begin
        if (accept) begin
          if (last_smp)            state_nx = DONE;
          else if (cfg.gap != '0)  state_nx = GAP;
          else                     state_nx = RUN;
        end
      end
      GAP:  if (gcnt <= GW'(1)) state_nx = RUN;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (abort_i) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg       <= '0;
      x         <= '0;
      y         <= '0;
      z         <= '0;
      gcnt      <= '0;
      en_o      <= 1'b0;
      done_o    <= 1'b0;
      data_o    <= '0;
      x_o       <= '0;
      y_o       <= '0;
      z_o       <= '0;
      first_x_o <= 1'b0;
      first_y_o <= 1'b0;
      first_z_o <= 1'b0;
      last_o    <= 1'b0;
    end else begin
      en_o   <= 1'b0;
      done_o <= 1'b0;
      if (abort_i) begin
        x    <= '0;
        y    <= '0;
        z    <= '0;
        gcnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start_i) begin
              cfg    <= '{nx: nx_i, ny: ny_i, nz: nz_i, gap: gap_i};
              x      <= '0;
              y      <= '0;
              z      <= '0;
              last_o <= 1'b0;
            end
          end
          RUN: begin
            if (accept) begin
              en_o      <= 1'b1;
              done_o    <= last_smp;
              data_o    <= s_data_i;
              x_o       <= x;
              y_o       <= y;
              z_o       <= z;
              first_x_o <= (x == '0);
              first_y_o <= (y == '0);
              first_z_o <= (z == '0);
              last_o    <= last_smp;
              gcnt      <= cfg.gap;
              // Counters stop on the final sample so they never pass the limits.
              if (!last_smp) begin
                if (z == cfg.nz) begin
                  z <= '0;
                  if (x == cfg.nx) begin
                    x <= '0;
                    y <= y + 1'b1;
                  end else begin
                    x <= x + 1'b1;
                  end
                end else begin
                  z <= z + 1'b1;
                end
              end
            end
          end
          GAP:     gcnt <= gcnt - 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/sample_scheduler.md
# sample_scheduler

Sequencing controller at the head of the simplified CCSDS-123 predictor pipeline. Accepts raw samples over a valid/ready stream, walks them through the image in band-interleaved-by-pixel order (z fastest, then x, then y) and issues one enable pulse plus sample data per accepted sample to the downstream delay/register stages. Tags each issued sample with its coordinates and edge flags. Enforces a programmable idle gap between issues so multi-cycle downstream stages are never overrun.

## Interface
- DATA_WIDH, 20, sample width
- XW, 8, width of x counter and nx_i
- YW, 8, width of y counter and ny_i
- ZW, 8, width of z counter and nz_i
- GW, 4, width of gap_i

- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  begin an image; sampled only in IDLE
- abort_i  in  1  synchronous abort; return to IDLE, no done pulse
- nx_i  in  XW  columns minus 1; latched on accepted start
- ny_i  in  YW  rows minus 1; latched on accepted start
- nz_i  in  ZW  bands minus 1; latched on accepted start
- gap_i  in  GW  idle cycles between issues; latched on accepted start
- s_valid_i  in  1  input sample valid
- s_data_i  in  DATA_WIDH  input sample
- s_ready_o  out  1  scheduler accepts a sample this cycle
- en_o  out  1  one-cycle issue pulse to pipeline
- data_o  out  DATA_WIDH  issued sample; holds between issues
- x_o / y_o / z_o  out  XW / YW / ZW  coordinates of issued sample
- first_x_o, first_y_o, first_z_o  out  1  coordinate of issued sample is 0
- last_o  out  1  issued sample is final one of image
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle pulse after final issue

## Operation
- States: IDLE, RUN, GAP, DONE. Encoding free.
- IDLE: s_ready_o=0. start_i=1 -> latch nx/ny/nz/gap, clear counters x=y=z=0, go RUN.
- RUN: s_ready_o=1. Accept = s_valid_i & s_ready_o. On accept:
  - register s_data_i to data_o, current x/y/z to x_o/y_o/z_o, flags derived from current counters, en_o=1 next cycle.
  - last = (x==nx)&(y==ny)&(z==nz). If last -> DONE (gap ignored).
  - else advance: z==nz ? (z=0; x==nx ? (x=0; y=y+1) : x=x+1) : z=z+1.
  - else gap==0 -> stay RUN; gap!=0 -> GAP, gap counter = gap.
  - No accept -> stay RUN, en_o=0, other outputs hold.
- GAP: s_ready_o=0; counter decrements each cycle; counter==1 -> RUN.
- DONE: done_o=1 for exactly one cycle, next state IDLE.
- abort_i=1 in any state: next state IDLE, no en_o or done_o generated that cycle, counters cleared; abort takes priority over start_i and accept (s_ready_o still combinationally 1 in RUN, but the sample is dropped; producer must not rely on it).
- start_i outside IDLE ignored. Config changes outside IDLE ignored.
- Counter compare uses latched dimensions only; nx/ny/nz=0 means a 1-wide dimension (single sample image allowed).
- Counters never wrap past latched limits; no arithmetic overflow possible.

## Timing
- Reset: state IDLE; s_ready_o, en_o, last_o, busy_o, done_o = 0; data_o, x_o, y_o, z_o = 0; first_* = 0; latched config = 0.
- s_ready_o is a decode of registered state only (no combinational path from s_valid_i).
- start_i at edge k -> busy_o=1 and s_ready_o=1 from cycle k+1.
- Accept at edge k -> en_o=1 with data/coords/flags valid during cycle k+1 (latency 1); outputs hold until next issue.
- Throughput: gap=0 one sample per cycle; gap=g one sample per g+1 cycles.
- Final accept at edge k -> en_o,last_o at k+1 (state DONE) with done_o=1 same cycle; busy_o falls at k+2. last_o clears on next issue or start.
- Earliest restart: start_i sampled at k+2.

## Test plan
- Reset mid-RUN: assert rst_n=0 during streaming -> all outputs 0 immediately, state IDLE, no en_o after release until new start.
- nx=1, ny=1, nz=2, gap=0, s_valid_i constantly 1 -> 12 consecutive en_o pulses, z sequence 0,1,2 repeating, x 0,0,0,1,1,1, y flips after 6; last_o and done_o on 12th; busy_o low 1 cycle later.
- Same image, gap=3 -> issues exactly 4 cycles apart, s_ready_o low 3 cycles after each accept except the final.
- Random s_valid_i deassertion (50%) with gap=0 -> issued data matches input order, no duplicates or drops, coordinates identical to no-stall run.
- Single-sample image nx=ny=nz=0 -> one en_o with first_x/y/z=1 and last_o=1, done_o same cycle.
- abort_i after 5 issues of 12, then start_i with new dims nx=0, ny=0, nz=1 -> no done_o for aborted image; new run issues 2 samples at (0,0,0),(0,0,1) with done_o.
